// File: rtl/alu.sv
// MIPS datapath ALU: AND/OR/ADD/SUB/SLT/NOR on two WIDTH-bit operands, result and zero flag registered.
// Latency: 1 cycle; operands and operation sampled on rising clk, outputs update on that same edge.
// Backpressure: none; a new operation is accepted every cycle and outputs are overwritten each edge.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] aluresult,
    output logic             zero
);

    // ALU-control codes produced by the decoder
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [WIDTH-1:0] next_result;
    logic             signed_lt;

    // Signed compare done directly rather than from the sign of a-b, so overflow cannot flip it
    assign signed_lt = ($signed(data_a) < $signed(data_b));

    // Next result; unknown codes yield 0 so nothing undefined reaches write-back
    always_comb begin
        next_result = '0;
        case (operation)
            OP_AND:  next_result = data_a & data_b;
            OP_OR:   next_result = data_a | data_b;
            OP_ADD:  next_result = data_a + data_b;
            OP_SUB:  next_result = data_a - data_b;
            OP_SLT:  next_result = {{(WIDTH-1){1'b0}}, signed_lt};
            OP_NOR:  next_result = ~(data_a | data_b);
            default: next_result = '0;
        endcase
    end

    // Result and zero registered together so zero always describes the visible aluresult
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluresult <= '0;
            zero      <= 1'b1;
        end else begin
            aluresult <= next_result;
            zero      <= (next_result == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [3:0]       operation;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [WIDTH-1:0] aluresult;
    logic             zero;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operation (operation),
        .data_a    (data_a),
        .data_b    (data_b),
        .aluresult (aluresult),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour; SLT and SUB worked out differently from a plain signed compare / minus
    function automatic logic [WIDTH-1:0] model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a + (~b) + 1;
            4'b0111: begin
                if (a[WIDTH-1] != b[WIDTH-1]) r = {{(WIDTH-1){1'b0}}, a[WIDTH-1]};
                else                          r = {{(WIDTH-1){1'b0}}, (a < b)};
            end
            4'b1100: r = ~(a | b);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Drive one operation at the falling edge, record what must appear after the next rising edge
    task automatic drive(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_res);
        exp_t e;
        @(negedge clk);
        operation = op;
        data_a    = a;
        data_b    = b;
        e.res = exp_res;
        e.z   = (exp_res == '0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b1; operation = 4'b0010; data_a = 32'h1234_5678; data_b = 32'h1111_1111;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (aluresult !== '0 || zero !== 1'b1)
            $display("FAIL reset_async: aluresult=%h zero=%b expected 0/1", aluresult, zero);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (aluresult !== '0 || zero !== 1'b1)
            $display("FAIL reset_hold: aluresult=%h zero=%b expected 0/1", aluresult, zero);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 32'h0, 32'h0, 32'h0);
        e = exp_q.pop_front();
        total++;
        if (aluresult !== e.res || zero !== e.z)
            $display("FAIL reset_release: aluresult=%h zero=%b expected %h/%b", aluresult, zero, e.res, e.z);
        else passed++;
    endtask

    task automatic test_logic();
        logic [3:0]       ops  [3] = '{4'b0000, 4'b0001, 4'b1100};
        logic [WIDTH-1:0] exps [3] = '{32'h0000_00A5, 32'h0000_A5FF, 32'hFFFF_5A00};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 32'h0000_A5A5, 32'h0000_00FF, exps[i]);
            e = exp_q.pop_front();
            total++;
            if (aluresult !== e.res || zero !== e.z)
                $display("FAIL logic_op%0d: aluresult=%h zero=%b expected %h/%b", ops[i], aluresult, zero, e.res, e.z);
            else passed++;
        end
    endtask

    task automatic test_arith();
        logic [3:0]       ops  [3] = '{4'b0010, 4'b0110, 4'b0010};
        logic [WIDTH-1:0] as   [3] = '{32'd7, 32'd7, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] bs   [3] = '{32'd35, 32'd35, 32'd1};
        logic [WIDTH-1:0] exps [3] = '{32'd42, 32'hFFFF_FFE4, 32'h0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], as[i], bs[i], exps[i]);
            e = exp_q.pop_front();
            total++;
            if (aluresult !== e.res || zero !== e.z)
                $display("FAIL arith_%0d: aluresult=%h zero=%b expected %h/%b", i, aluresult, zero, e.res, e.z);
            else passed++;
        end
    endtask

    task automatic test_slt();
        logic [WIDTH-1:0] as   [5] = '{32'd7, 32'd42, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [WIDTH-1:0] bs   [5] = '{32'd35, 32'd35, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [WIDTH-1:0] exps [5] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0111, as[i], bs[i], exps[i]);
            e = exp_q.pop_front();
            total++;
            if (aluresult !== e.res || zero !== e.z)
                $display("FAIL slt_%0d: aluresult=%h zero=%b expected %h/%b", i, aluresult, zero, e.res, e.z);
            else passed++;
        end
    endtask

    task automatic test_undefined();
        exp_t e;
        drive(4'b0010, 32'd5, 32'd6, 32'd11);
        void'(exp_q.pop_front());
        drive(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
        e = exp_q.pop_front();
        total++;
        if (aluresult !== e.res || zero !== e.z)
            $display("FAIL undefined_op: aluresult=%h zero=%b expected %h/%b", aluresult, zero, e.res, e.z);
        else passed++;
    endtask

    // Operands change every cycle; output must hold the previous result until the edge, then the new one
    task automatic test_back_to_back();
        exp_t       e;
        exp_t       prev;
        logic [3:0] op;
        logic [WIDTH-1:0] a, b;
        prev.res = aluresult;
        prev.z   = zero;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            if (i % 3 == 0) op = 4'b0111;
            a  = $urandom;
            b  = (i % 5 == 0) ? a : $urandom;
            @(negedge clk);
            operation = op; data_a = a; data_b = b;
            e.res = model(op, a, b);
            e.z   = (e.res == '0);
            exp_q.push_back(e);
            #1;
            total++;
            if (aluresult !== prev.res || zero !== prev.z)
                $display("FAIL b2b_hold_%0d: aluresult=%h zero=%b expected %h/%b", i, aluresult, zero, prev.res, prev.z);
            else passed++;
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (aluresult !== e.res || zero !== e.z)
                $display("FAIL b2b_%0d op=%h: aluresult=%h zero=%b expected %h/%b", i, op, aluresult, zero, e.res, e.z);
            else passed++;
            prev = e;
        end
    endtask

    task automatic test_reset_mid_stream();
        exp_t e;
        drive(4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        e = exp_q.pop_front();
        total++;
        if (aluresult !== e.res || zero !== e.z)
            $display("FAIL midrst_pre: aluresult=%h zero=%b expected %h/%b", aluresult, zero, e.res, e.z);
        else passed++;
        operation = 4'b0010; data_a = 32'd100; data_b = 32'd23;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (aluresult !== '0 || zero !== 1'b1)
            $display("FAIL midrst_drop: aluresult=%h zero=%b expected 0/1", aluresult, zero);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (aluresult !== '0 || zero !== 1'b1)
            $display("FAIL midrst_discard: aluresult=%h zero=%b expected 0/1", aluresult, zero);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0010, 32'd100, 32'd23, 32'd123);
        e = exp_q.pop_front();
        total++;
        if (aluresult !== e.res || zero !== e.z)
            $display("FAIL midrst_resume: aluresult=%h zero=%b expected %h/%b", aluresult, zero, e.res, e.z);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_logic();
        test_arith();
        test_slt();
        test_undefined();
        test_back_to_back();
        test_reset_mid_stream();
        total++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
